pattern_checker: RTL and testbench
==================================

// Module: pattern_checker
// PURPOSE
//  Receive-side checker for the 3-bit frame pattern generator.
//  The generator drives START (101), then MID (111), then FILL (000) on every following
//  cycle; it updates its bus on the falling clk edge.
//  This block samples that bus on the rising clk edge, which is mid-cycle relative to the
//  generator, and tracks the sequence with an FSM.
//  It reports lock, sequence-complete and error events, and keeps saturating statistics
//  for bring-up and self-test logic.
// PARAMETERS
//  W          3      bus width of a_in
//  START      3'b101 first pattern word
//  MID        3'b111 second pattern word
//  FILL       3'b000 repeating fill word
//  LOCK_FILLS 4      consecutive FILL words in STEADY needed to assert locked (1..2^FILL_W-1)
//  FILL_W     4      width of fill_cnt
//  CNT_W      8      width of err_cnt
// PORTS
//  clk       in  1       rising-edge sample clock
//  rst       in  1       async active-high reset
//  a_in      in  W       pattern bus from the generator
//  en        in  1       sample enable; when 0, FSM and counters hold
//  clr_cnt   in  1       sync clear of err_cnt
//  state     out 2       FSM state: 0 HUNT, 1 SEEN_START, 2 SEEN_MID, 3 STEADY
//  seq_ok    out 1       1-cycle pulse when entering STEADY
//  err       out 1       1-cycle pulse on a sequence violation
//  locked    out 1       high while fill_cnt >= LOCK_FILLS in STEADY
//  fill_cnt  out FILL_W  consecutive FILL count in STEADY; saturates at all-ones
//  err_cnt   out CNT_W   violation count; saturates at all-ones
// BEHAVIOUR
//  - Reset (async, rst=1): state=HUNT; seq_ok, err, locked, fill_cnt and err_cnt all 0.
//  - All outputs are registered; each reflects the a_in sampled at the same rising edge,
//    so it is visible 1 cycle after the sample.
//  - en=0: no state change, no pulses (seq_ok=err=0), counters hold. clr_cnt still acts.
//  - Transitions, with en=1 and d = a_in at the edge:
//    HUNT:       d==START -> SEEN_START; anything else -> stay. Never flags err.
//    SEEN_START: d==MID -> SEEN_MID.
//                d==START -> stay SEEN_START, err=1.
//                anything else -> HUNT, err=1.
//    SEEN_MID:   d==FILL -> STEADY, seq_ok=1, fill_cnt=1.
//                d==START -> SEEN_START, err=1.
//                anything else -> HUNT, err=1.
//    STEADY:     d==FILL -> fill_cnt+1 (saturating).
//                d==START -> SEEN_START, err=1, fill_cnt=0.
//                anything else -> HUNT, err=1, fill_cnt=0.
//  - locked: set on the edge where fill_cnt reaches LOCK_FILLS; cleared on the same edge
//    that leaves STEADY.
//  - err_cnt: +1 on each err pulse; holds at all-ones.
//  - clr_cnt=1 forces err_cnt=0 and wins over a same-cycle err. The err pulse itself is
//    still emitted.
//  - fill_cnt: holds at 2^FILL_W-1; locked stays 1 while it is saturated.
//  - rst mid-sequence returns to HUNT at once; the next START is accepted normally.
// TESTING
//  1. rst, then 101,111,000,000,000,000 ->
//     seq_ok pulses 1 cycle after the first 000; locked=1 after the 4th 000; err_cnt=0.
//  2. Lock achieved, then inject 010 ->
//     err pulse, locked=0, state=HUNT, fill_cnt=0, err_cnt=1.
//  3. 101,101,111,000 ->
//     err on the 2nd 101 with state staying SEEN_START; sequence then completes;
//     err_cnt=1.
//  4. Force err_cnt to 255 with repeated 101,000 pairs, then one more violation ->
//     err_cnt holds at 255.
//     Then assert clr_cnt together with a violation -> err_cnt=0, err=1.
//  5. en=0 for 3 cycles in the middle of 101,111 with garbage on a_in ->
//     state unchanged and no err; after en=1, 000 gives seq_ok.
//  6. 20 consecutive 000 in STEADY -> fill_cnt saturates at 15, locked stays 1.
//     Then assert rst asynchronously between edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/pattern_checker.sv
// Receive-side checker for the START/MID/FILL frame pattern generator.
// Tracks the sequence with an FSM and keeps saturating fill and error statistics.
module pattern_checker #(
    parameter int unsigned     W          = 3,
    parameter logic [W-1:0]    START      = 3'b101,
    parameter logic [W-1:0]    MID        = 3'b111,
    parameter logic [W-1:0]    FILL       = 3'b000,
    parameter int unsigned     LOCK_FILLS = 4,
    parameter int unsigned     FILL_W     = 4,
    parameter int unsigned     CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      a_in,
    input  logic              en,
    input  logic              clr_cnt,
    output logic [1:0]        state,
    output logic              seq_ok,
    output logic              err,
    output logic              locked,
    output logic [FILL_W-1:0] fill_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    typedef enum logic [1:0] {
        HUNT       = 2'd0,
        SEEN_START = 2'd1,
        SEEN_MID   = 2'd2,
        STEADY     = 2'd3
    } state_t;

    state_t             cur_state, nxt_state;
    logic               nxt_seq_ok, nxt_err, nxt_locked;
    logic [FILL_W-1:0]  nxt_fill;
    logic [CNT_W-1:0]   nxt_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= HUNT;
            seq_ok    <= 1'b0;
            err       <= 1'b0;
            locked    <= 1'b0;
            fill_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            cur_state <= nxt_state;
            seq_ok    <= nxt_seq_ok;
            err       <= nxt_err;
            locked    <= nxt_locked;
            fill_cnt  <= nxt_fill;
            err_cnt   <= nxt_err_cnt;
        end
    end

    always_comb begin
        nxt_state  = cur_state;
        nxt_seq_ok = 1'b0;
        nxt_err    = 1'b0;
        nxt_fill   = fill_cnt;
        if (en) begin
            case (cur_state)
                HUNT: begin
                    if (a_in == START) nxt_state = SEEN_START;
                end
                SEEN_START: begin
                    if (a_in == MID) begin
                        nxt_state = SEEN_MID;
                    end else begin
                        nxt_err   = 1'b1;
                        nxt_state = (a_in == START) ? SEEN_START : HUNT;
                    end
                end
                SEEN_MID: begin
                    if (a_in == FILL) begin
                        nxt_state  = STEADY;
                        nxt_seq_ok = 1'b1;
                        nxt_fill   = FILL_W'(1);
                    end else begin
                        nxt_err   = 1'b1;
                        nxt_state = (a_in == START) ? SEEN_START : HUNT;
                    end
                end
                STEADY: begin
                    if (a_in == FILL) begin
                        if (fill_cnt != '1) nxt_fill = fill_cnt + FILL_W'(1);
                    end else begin
                        nxt_err   = 1'b1;
                        nxt_fill  = '0;
                        nxt_state = (a_in == START) ? SEEN_START : HUNT;
                    end
                end
                default: nxt_state = HUNT;
            endcase
        end

        // locked follows the registered fill count, so it drops on the same edge that leaves STEADY
        nxt_locked = (nxt_state == STEADY) && (nxt_fill >= FILL_W'(LOCK_FILLS));

        nxt_err_cnt = err_cnt;
        if (clr_cnt)
            nxt_err_cnt = '0;
        else if (nxt_err && (err_cnt != '1))
            nxt_err_cnt = err_cnt + CNT_W'(1);
    end

    assign state = cur_state;

endmodule

// File: tb/tb_pattern_checker.sv
// Directed bench for pattern_checker: inputs change on the falling edge like the
// generator, outputs are checked on the following falling edge.
module tb_pattern_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] a_in = 3'b000;
    logic       en = 1'b1;
    logic       clr_cnt = 1'b0;
    logic [1:0] state;
    logic       seq_ok, err, locked;
    logic [3:0] fill_cnt;
    logic [7:0] err_cnt;

    int checks = 0;
    int failures = 0;

    pattern_checker #(
        .W(3), .START(3'b101), .MID(3'b111), .FILL(3'b000),
        .LOCK_FILLS(4), .FILL_W(4), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .a_in(a_in), .en(en), .clr_cnt(clr_cnt),
        .state(state), .seq_ok(seq_ok), .err(err), .locked(locked),
        .fill_cnt(fill_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Present one word, let the rising edge sample it, return at the next falling edge.
    task automatic step(input logic [2:0] d);
        a_in = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; a_in = 3'b000; en = 1'b1; clr_cnt = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_state", state, 0);
        check("rst_flags", {seq_ok, err, locked}, 0);
        check("rst_fill", fill_cnt, 0);
        check("rst_errcnt", err_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: clean sequence and lock
        do_reset();
        step(3'b101); check("t1_state_ss", state, 1); check("t1_err0", err, 0);
        step(3'b111); check("t1_state_sm", state, 2);
        step(3'b000); check("t1_seq_ok", seq_ok, 1); check("t1_state_st", state, 3);
        check("t1_fill1", fill_cnt, 1); check("t1_nolock1", locked, 0);
        step(3'b000); check("t1_seq_ok_pulse", seq_ok, 0); check("t1_fill2", fill_cnt, 2);
        step(3'b000); check("t1_fill3", fill_cnt, 3); check("t1_nolock3", locked, 0);
        step(3'b000); check("t1_fill4", fill_cnt, 4); check("t1_locked", locked, 1);
        check("t1_errcnt", err_cnt, 0);

        // 2: violation while locked
        step(3'b010);
        check("t2_err", err, 1); check("t2_locked", locked, 0); check("t2_state", state, 0);
        check("t2_fill", fill_cnt, 0); check("t2_errcnt", err_cnt, 1);
        step(3'b000); check("t2_err_pulse", err, 0); check("t2_hunt_stay", state, 0);

        // 3: repeated START
        do_reset();
        step(3'b101); check("t3_err0", err, 0);
        step(3'b101); check("t3_err", err, 1); check("t3_state", state, 1);
        step(3'b111); check("t3_state_sm", state, 2); check("t3_err_pulse", err, 0);
        step(3'b000); check("t3_seq_ok", seq_ok, 1); check("t3_errcnt", err_cnt, 1);

        // 4: err_cnt saturation, then clear beating a same-cycle error
        do_reset();
        for (int i = 0; i < 255; i++) begin
            step(3'b101);
            step(3'b000);
        end
        check("t4_errcnt255", err_cnt, 255);
        step(3'b101);
        step(3'b000); check("t4_sat_err", err, 1); check("t4_sat_hold", err_cnt, 255);
        step(3'b101);
        clr_cnt = 1'b1;
        step(3'b000); check("t4_clr_err", err, 1); check("t4_clr_cnt", err_cnt, 0);
        clr_cnt = 1'b0;

        // 5: enable gap with garbage on the bus
        do_reset();
        step(3'b101); check("t5_state_ss", state, 1);
        en = 1'b0;
        step(3'b010); check("t5_hold_a", state, 1); check("t5_noerr_a", err, 0);
        step(3'b110); check("t5_hold_b", state, 1); check("t5_noerr_b", err, 0);
        step(3'b101); check("t5_hold_c", state, 1); check("t5_noerr_c", err, 0);
        en = 1'b1;
        step(3'b111); check("t5_state_sm", state, 2);
        step(3'b000); check("t5_seq_ok", seq_ok, 1); check("t5_errcnt", err_cnt, 0);

        // 6: fill saturation (already at 1), then async reset between edges
        for (int i = 0; i < 20; i++) begin
            step(3'b000);
            if (i == 13) check("t6_fill15", fill_cnt, 15);
        end
        check("t6_fill_sat", fill_cnt, 15); check("t6_locked", locked, 1);
        check("t6_state", state, 3);
        #2 rst = 1'b1;
        #1;
        check("t6_arst_state", state, 0);
        check("t6_arst_flags", {seq_ok, err, locked}, 0);
        check("t6_arst_fill", fill_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        step(3'b101); check("t6_restart", state, 1); check("t6_restart_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
